// File: rtl/brlite_svc_buffer_pkg.sv
// Types and constants shared by the BrLite service receive buffer and its FIFO.
package brlite_svc_buffer_pkg;

  localparam logic [1:0] BR_SVC_TGT = 2'd0;
  localparam logic [1:0] BR_SVC_ALL = 2'd1;
  localparam logic [1:0] BR_SVC_MON = 2'd2;
  localparam logic [1:0] BR_SVC_CLR = 2'd3;

  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_flit_t;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_ACK      = 2'd1,
    RX_WAIT_LOW = 2'd2
  } rx_state_e;

  localparam int unsigned BRLITE_SVC_W = $bits(brlite_svc_t);

  // Strip the routing service code; the NI only needs the message body.
  function automatic brlite_svc_t flit_to_svc(input brlite_flit_t f);
    brlite_svc_t s;
    s.ksvc       = f.ksvc;
    s.seq_source = f.seq_source;
    s.producer   = f.producer;
    s.payload    = f.payload;
    return s;
  endfunction

endpackage

// File: rtl/brlite_svc_fifo.sv
// Generic synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty.
module brlite_svc_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 72
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally; count tracks occupancy independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/brlite_svc_buffer.sv
// BrLite local-port receive endpoint: req/ack capture, monitor filter, service FIFO to the NI.
// BRLITE_SVC_DROP_CNT_EN: drop-and-count flits that arrive while full instead of back-pressuring.
module brlite_svc_buffer
  import brlite_svc_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
`ifdef BRLITE_SVC_DROP_CNT_EN
  , parameter int unsigned DROP_CNT_W = 16
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   br_req_i,
  output logic                   br_ack_o,
  input  brlite_flit_t           br_data_i,
  output logic                   br_svc_rx_o,
  input  logic                   br_svc_ack_i,
  output brlite_svc_t            br_svc_data_o,
  output logic [$clog2(DEPTH):0] br_svc_count_o
`ifdef BRLITE_SVC_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0] br_svc_drops_o
`endif
);

  rx_state_e   state_q;
  rx_state_e   state_d;
  logic        is_mon;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept_c;
  logic        push_c;
  logic        ack_d;
  logic        ack_q;
  brlite_svc_t fifo_din;
  brlite_svc_t fifo_dout;

  assign is_mon   = (br_data_i.service == BR_SVC_MON);
  assign fifo_din = flit_to_svc(br_data_i);

  // Capture decision uses the pre-edge fill level; no same-cycle bypass.
`ifdef BRLITE_SVC_DROP_CNT_EN
  assign accept_c = (state_q == RX_IDLE) && br_req_i;
`else
  assign accept_c = (state_q == RX_IDLE) && br_req_i && (is_mon || !fifo_full);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:     if (accept_c) state_d = RX_ACK;
      RX_ACK:      state_d = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!br_req_i) state_d = RX_IDLE;
      default:     state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ack_d  = 1'b0;
    push_c = 1'b0;
    ack_d  = (state_d == RX_ACK);
    push_c = accept_c && !is_mon && !fifo_full;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ack_q <= 1'b0;
    else         ack_q <= ack_d;
  end

  assign br_ack_o    = ack_q;
  assign br_svc_rx_o = !fifo_empty;
  assign br_svc_data_o = fifo_dout;

  brlite_svc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BRLITE_SVC_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push_c),
    .pop   (br_svc_ack_i),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (br_svc_count_o)
  );

`ifdef BRLITE_SVC_DROP_CNT_EN
  logic                  drop_c;
  logic [DROP_CNT_W-1:0] drops_q;

  assign drop_c = accept_c && !is_mon && fifo_full;

  // Saturating count of flits discarded for lack of space.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                          drops_q <= '0;
    else if (drop_c && (drops_q != '1))   drops_q <= drops_q + DROP_CNT_W'(1);
  end

  assign br_svc_drops_o = drops_q;
`endif

endmodule

// File: tb/tb_brlite_svc_buffer.sv
// Self-checking bench for brlite_svc_buffer: vector table plus scoreboarded corner sequences.
module tb_brlite_svc_buffer;
  import brlite_svc_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         ack;
  brlite_flit_t data;
  logic         rx;
  logic         svc_ack;
  brlite_svc_t  svc_data;
  logic [3:0]   count;
`ifdef BRLITE_SVC_DROP_CNT_EN
  logic [15:0]  drops;
`endif

  int n_vec = 0;
  int n_err = 0;
  brlite_svc_t sb[$];

  brlite_svc_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .br_req_i       (req),
    .br_ack_o       (ack),
    .br_data_i      (data),
    .br_svc_rx_o    (rx),
    .br_svc_ack_i   (svc_ack),
    .br_svc_data_o  (svc_data),
    .br_svc_count_o (count)
`ifdef BRLITE_SVC_DROP_CNT_EN
    , .br_svc_drops_o (drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic brlite_svc_t to_svc(input brlite_flit_t f);
    brlite_svc_t s;
    s.ksvc = f.ksvc;
    s.seq_source = f.seq_source;
    s.producer = f.producer;
    s.payload = f.payload;
    return s;
  endfunction

  function automatic brlite_flit_t mk(input logic [1:0] svc, input int idx);
    brlite_flit_t f;
    f.service    = svc;
    f.ksvc       = 8'(idx + 64);
    f.seq_source = 16'(idx * 3 + 1);
    f.producer   = 16'h0100 + 16'(idx);
    f.payload    = 32'hC0DE0000 ^ 32'(idx * 7919);
    return f;
  endfunction

  // Offer one flit; all tasks start and end 1 time unit after a rising edge.
  task automatic send(input brlite_flit_t f, input logic exp_ack, input logic exp_push,
                      input int exp_cnt, input string tag);
    int lat;
    lat = 0;
    req = 1'b1;
    data = f;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_ack"}, 128'(lat != 0), 128'(exp_ack));
    if (exp_push) sb.push_back(to_svc(f));
    req = 1'b0;
    if (lat != 0) begin
      chk({tag, "_lat"}, 128'(lat), 128'(1));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 128'(ack), 128'(0));
    end
    @(posedge clk); #1;
    chk({tag, "_cnt"}, 128'(count), 128'(exp_cnt));
    chk({tag, "_rx"}, 128'(rx), 128'(exp_cnt != 0));
  endtask

  task automatic pop_one(input int exp_cnt, input string tag);
    bit had;
    brlite_svc_t e;
    had = (sb.size() != 0);
    chk({tag, "_rx"}, 128'(rx), 128'(had));
    if (had) begin
      e = sb.pop_front();
      chk({tag, "_data"}, 128'(svc_data), 128'(e));
    end
    svc_ack = 1'b1;
    @(posedge clk); #1;
    svc_ack = 1'b0;
    chk({tag, "_cnt"}, 128'(count), 128'(exp_cnt));
  endtask

  typedef struct {
    logic         is_pop;
    brlite_flit_t flit;
    logic         exp_ack;
    int           exp_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    brlite_flit_t f1;
    brlite_flit_t f;
    int extra;
    int lat;
    bit got;

    f1.service = BR_SVC_ALL;
    f1.ksvc = 8'h12;
    f1.seq_source = 16'h0003;
    f1.producer = 16'h0102;
    f1.payload = 32'hDEADBEEF;

    tbl[0] = '{is_pop: 1'b0, flit: f1,                 exp_ack: 1'b1, exp_cnt: 1};
    tbl[1] = '{is_pop: 1'b1, flit: '0,                 exp_ack: 1'b0, exp_cnt: 0};
    tbl[2] = '{is_pop: 1'b0, flit: mk(BR_SVC_MON, 1),  exp_ack: 1'b1, exp_cnt: 0};
    tbl[3] = '{is_pop: 1'b0, flit: mk(BR_SVC_TGT, 2),  exp_ack: 1'b1, exp_cnt: 1};
    tbl[4] = '{is_pop: 1'b0, flit: mk(BR_SVC_CLR, 3),  exp_ack: 1'b1, exp_cnt: 2};
    tbl[5] = '{is_pop: 1'b1, flit: '0,                 exp_ack: 1'b0, exp_cnt: 1};
    tbl[6] = '{is_pop: 1'b1, flit: '0,                 exp_ack: 1'b0, exp_cnt: 0};
    tbl[7] = '{is_pop: 1'b1, flit: '0,                 exp_ack: 1'b0, exp_cnt: 0};

    rst_n = 1'b0;
    req = 1'b0;
    svc_ack = 1'b0;
    data = '0;

    // Reset state after the first edge
    @(posedge clk); #1;
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_rx", 128'(rx), 128'(0));
    chk("rst_cnt", 128'(count), 128'(0));
`ifdef BRLITE_SVC_DROP_CNT_EN
    chk("rst_drops", 128'(drops), 128'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic flits, monitor filtering, pops including pop on empty
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].is_pop)
        pop_one(tbl[i].exp_cnt, $sformatf("vec%0d", i));
      else
        send(tbl[i].flit, tbl[i].exp_ack,
             tbl[i].exp_ack && (tbl[i].flit.service != BR_SVC_MON),
             tbl[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // Request held high long after the ack: exactly one capture
    f = mk(BR_SVC_TGT, 20);
    req = 1'b1;
    data = f;
    @(posedge clk); #1;
    chk("hold_ack", 128'(ack), 128'(1));
    sb.push_back(to_svc(f));
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    chk("hold_extra_acks", 128'(extra), 128'(0));
    chk("hold_cnt", 128'(count), 128'(1));
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(mk(BR_SVC_ALL, 21), 1'b1, 1'b1, 2, "rearm");
    pop_one(1, "hold_pop0");
    pop_one(0, "hold_pop1");

    // Fill to DEPTH, then the ninth flit
    for (int i = 0; i < DEPTH; i++)
      send(mk(BR_SVC_ALL, 100 + i), 1'b1, 1'b1, i + 1, $sformatf("fill%0d", i));
`ifdef BRLITE_SVC_DROP_CNT_EN
    send(mk(BR_SVC_TGT, 108), 1'b1, 1'b0, DEPTH, "drop9");
    chk("drops_one", 128'(drops), 128'(1));
`else
    f = mk(BR_SVC_TGT, 108);
    req = 1'b1;
    data = f;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    chk("full_noack", 128'(got), 128'(0));
    chk("full_cnt", 128'(count), 128'(DEPTH));
    pop_one(DEPTH - 1, "full_pop");
    lat = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        break;
      end
    end
    chk("full_ack_after_pop", 128'(lat), 128'(1));
    sb.push_back(to_svc(f));
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full_refill_cnt", 128'(count), 128'(DEPTH));
`endif

    // Order across pointer wrap
    for (int k = 0; k < 11; k++) begin
      pop_one(DEPTH - 1, $sformatf("wrap_pop%0d", k));
      send(mk((k % 2) != 0 ? BR_SVC_TGT : BR_SVC_CLR, 200 + k), 1'b1, 1'b1, DEPTH,
           $sformatf("wrap_send%0d", k));
    end
    for (int j = 0; j < DEPTH; j++)
      pop_one(DEPTH - 1 - j, $sformatf("drain%0d", j));

    // Simultaneous push and pop at count 4
    for (int i = 0; i < 4; i++)
      send(mk(BR_SVC_ALL, 300 + i), 1'b1, 1'b1, i + 1, $sformatf("pp_fill%0d", i));
    chk("pp_head0", 128'(svc_data), 128'(sb[0]));
    void'(sb.pop_front());
    f = mk(BR_SVC_CLR, 304);
    sb.push_back(to_svc(f));
    req = 1'b1;
    data = f;
    svc_ack = 1'b1;
    @(posedge clk); #1;
    svc_ack = 1'b0;
    chk("pp_ack", 128'(ack), 128'(1));
    chk("pp_cnt", 128'(count), 128'(4));
    chk("pp_head1", 128'(svc_data), 128'(sb[0]));
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++)
      pop_one(3 - j, $sformatf("pp_drain%0d", j));
    pop_one(0, "pop_empty");

    // Reset while the ack is high
    req = 1'b1;
    data = mk(BR_SVC_ALL, 400);
    @(posedge clk); #1;
    chk("mid_ack", 128'(ack), 128'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack", 128'(ack), 128'(0));
    chk("mid_rst_cnt", 128'(count), 128'(0));
    chk("mid_rst_rx", 128'(rx), 128'(0));
`ifdef BRLITE_SVC_DROP_CNT_EN
    chk("mid_rst_drops", 128'(drops), 128'(0));
`endif
    sb.delete();
    req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(mk(BR_SVC_TGT, 401), 1'b1, 1'b1, 1, "post_rst");
    pop_one(0, "post_rst_pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/brlite_svc_buffer.md
Name: brlite_svc_buffer

Overview:
- Receive-side endpoint of the BrLite local port.
- Accepts flits from the BrLite router with a four-phase req/ack handshake and discards monitor-service flits.
- Buffers the remaining service messages in a FIFO.
- Presents the FIFO head to the NI as br_svc_rx/br_svc_data; the NI pops with a one-cycle br_svc_ack pulse.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
DROP_CNT_W, 16, width of the overflow drop counter (used only with the optional feature)

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; synchronous, active-low
br_req_i  input  1  router flit request; held high with stable data until ack is seen
br_ack_o  output  1  flit acknowledge to the router; one-cycle pulse
br_data_i  input  brlite_flit_t  router flit {service[1:0], ksvc[7:0], seq_source[15:0], producer[15:0], payload[31:0]}
br_svc_rx_o  output  1  FIFO non-empty; drives the NI br_svc_rx_i
br_svc_ack_i  input  1  NI pop pulse
br_svc_data_o  output  brlite_svc_t  FIFO head {ksvc, seq_source, producer, payload}
br_svc_count_o  output  $clog2(DEPTH)+1  current occupancy
br_svc_drops_o  output  DROP_CNT_W  saturating drop count; only exists with BRLITE_SVC_DROP_CNT_EN

Behaviour:
- Reset: all outputs 0 on the first rising edge with rst_ni=0. Pointers and count are 0, FSM is IDLE, FIFO contents are don't-care.
- br_svc_data_o is the combinational head read; it is undefined-but-stable when empty (bench must not check it).
- Rx FSM states:
  - IDLE: if br_req_i and (service==BR_SVC_MON or count<DEPTH), go to ACK.
    - Capture happens on this edge: push when service!=BR_SVC_MON; MON flits are consumed without a push.
    - If the FIFO is full and the flit is not MON, stay in IDLE; ack is withheld (back-pressure).
  - ACK: br_ack_o=1 for exactly this cycle (registered), then go to WAIT_LOW.
  - WAIT_LOW: go to IDLE when br_req_i==0.
    - This prevents a still-high req from being captured twice.
- Latency:
  - Req high to ack high: 1 cycle.
  - Push to br_svc_rx_o high: 1 cycle.
- Minimum handshake: 3 cycles per flit.
- Pop: when br_svc_ack_i=1 and count>0, the read pointer advances and the head updates next cycle.
  - A pop on empty is ignored, with no underflow.
- Simultaneous push and pop: both occur and count is unchanged.
  - When full, the push is still blocked, because the full test uses the pre-edge count; there is no bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is incremented/decremented independently.
- Reset mid-handshake: FSM returns to IDLE and ack drops. The router must deassert req before it reasserts.
- Service codes live in the package: BR_SVC_TGT=0, BR_SVC_ALL=1, BR_SVC_MON=2, BR_SVC_CLR=3.
  - All codes except MON are buffered.

Optional Feature:
BRLITE_SVC_DROP_CNT_EN
- Defined (overflow-drop mode):
  - In IDLE, a non-MON flit arriving while full is acked and discarded; it is never stalled.
  - br_svc_drops_o increments by 1 per dropped flit, saturates at all-ones, and clears only on reset.
- Undefined (back-pressure mode):
  - Full means back-pressure; the port br_svc_drops_o and its counter are absent.

Decomposition:
- DMNIPkg gains the following; brlite_svc_t is reused from DMNIPkg:
  - brlite_flit_t packed struct.
  - Service localparams BR_SVC_TGT/ALL/MON/CLR.
  - Rx FSM enum {RX_IDLE, RX_ACK, RX_WAIT_LOW}.
- Sub-module brlite_svc_fifo: generic synchronous FIFO with parameters DEPTH and type/width; ports push, pop, data in/out, empty, full, count. The top holds the FSM, filter and drop counter.

Test Plan:
1. Reset then single flit {ALL, ksvc=0x12, src=0x0003, prod=0x0102, pay=0xDEADBEEF}: ack pulse 1 cycle after req, rx=1 next cycle, data_o matches, count=1; NI ack pulse -> rx=0, count=0.
2. MON flit: ack pulse, count stays 0, rx stays 0.
3. Req held high 10 cycles after ack: exactly one push, count=1, no second ack until req low then high again.
4. DEPTH=8 full: the 9th ALL flit gets no ack while full; one NI pop -> ack follows. FIFO order is checked across pointer wrap over 20 flits. With the macro defined instead: 9th flit acked, drops=1, count stays 8.
5. Push and pop on the same edge at count=4 -> count=4, head advances; pop on empty -> count=0, no error.
6. rst_ni=0 during ACK: ack=0, count=0, rx=0 after the edge.
